// File: rtl/eth_tx_frame_buffer_if.sv
// Bundle between the AXI write path, the TX frame buffer and the RMII serializer.
// The buffer side uses the slave modport; the write path and serializer use master.
interface eth_tx_frame_buffer_if;
  logic [31:0] tx_data_in;
  logic        tx_valid;
  logic        last_data;
  logic        tx_send;
  logic        tx_ready_to_write;
  logic        tx_ready_to_send;
  logic        tx_done;
  logic        overflow;
  logic [10:0] frame_len;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  modport master (
    output tx_data_in, tx_valid, last_data, tx_send, m_ready,
    input  tx_ready_to_write, tx_ready_to_send, tx_done, overflow,
    input  frame_len, m_data, m_valid, m_last
  );

  modport slave (
    input  tx_data_in, tx_valid, last_data, tx_send, m_ready,
    output tx_ready_to_write, tx_ready_to_send, tx_done, overflow,
    output frame_len, m_data, m_valid, m_last
  );
endinterface

// File: rtl/eth_tx_frame_buffer.sv
// Ethernet TX frame buffer: stores one frame of 32-bit words and streams it
// out byte-wise (LSB first) with zero padding up to the minimum length.
module eth_tx_frame_buffer #(
  parameter int MAX_WORDS = 379,
  parameter int MIN_BYTES = 60,
  parameter int CNT_W     = 9
) (
  input  logic                 clk_100_mhz,
  input  logic                 rst_n,
  eth_tx_frame_buffer_if.slave bus
);
  typedef enum logic [1:0] {
    FILL, LOADED, SEND, DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [10:0]      MIN_LEN = 11'(MIN_BYTES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
  logic [10:0]      bcnt, bcnt_nxt;
  logic             primed;
  logic [31:0]      mem [MAX_WORDS];
  logic [31:0]      rd_data;
  logic [CNT_W-1:0] rd_addr;
  logic             has_room, wr_en, hs, load;
  logic [10:0]      data_bytes, data_nxt, len_nxt;
  logic [7:0]       byte_c;

  logic        rdy_wr, rdy_send, done, ovf;
  logic [10:0] flen;
  logic [7:0]  m_data;
  logic        m_valid, m_last;

  assign bus.tx_ready_to_write = rdy_wr;
  assign bus.tx_ready_to_send  = rdy_send;
  assign bus.tx_done           = done;
  assign bus.overflow          = ovf;
  assign bus.frame_len         = flen;
  assign bus.m_data            = m_data;
  assign bus.m_valid           = m_valid;
  assign bus.m_last            = m_last;

  always_comb begin
    has_room   = wr_cnt < MAX_CNT;
    wr_en      = (state == FILL) && bus.tx_valid && has_room;
    hs         = m_valid && bus.m_ready;
    load       = (state == SEND) && primed && (bcnt < flen) &&
                 (!m_valid || bus.m_ready);
    data_bytes = 11'({wr_cnt, 2'b00});
    byte_c     = (bcnt >= data_bytes) ? 8'h00 :
                 rd_data[{bcnt[1:0], 3'b000} +: 8];
  end

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    bcnt_nxt   = bcnt;
    unique case (state)
      FILL: begin
        if (wr_en) wr_cnt_nxt = wr_cnt + 1'b1;
        if (bus.last_data && wr_cnt_nxt != '0) state_nxt = LOADED;
      end
      LOADED: begin
        if (bus.tx_send) begin
          state_nxt = SEND;
          bcnt_nxt  = '0;
        end
      end
      SEND: begin
        if (load) bcnt_nxt = bcnt + 11'd1;
        if (hs && m_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt  = FILL;
        wr_cnt_nxt = '0;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    data_nxt = 11'({wr_cnt_nxt, 2'b00});
    len_nxt  = (data_nxt < MIN_LEN) ? MIN_LEN : data_nxt;
    // Address follows the byte that the next edge will load, so the word
    // for a new lane group is already in rd_data when it is needed.
    rd_addr  = (bcnt_nxt[10:2] < 9'(MAX_WORDS)) ?
               CNT_W'(bcnt_nxt[10:2]) : '0;
  end

  always_ff @(posedge clk_100_mhz) begin
    if (wr_en) mem[wr_cnt] <= bus.tx_data_in;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      bcnt     <= '0;
      primed   <= 1'b0;
      rdy_wr   <= 1'b0;
      rdy_send <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      flen     <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      wr_cnt   <= wr_cnt_nxt;
      bcnt     <= bcnt_nxt;
      primed   <= state == SEND;
      rdy_wr   <= (state_nxt == FILL) && (wr_cnt_nxt < MAX_CNT);
      rdy_send <= state_nxt == LOADED;
      done     <= state_nxt == DONE;
      ovf      <= (state == FILL) && bus.tx_valid && !has_room;
      if (state == FILL && state_nxt == LOADED) flen <= len_nxt;
      else if (state == DONE)                   flen <= '0;
      if (load) begin
        m_data  <= byte_c;
        m_valid <= 1'b1;
        m_last  <= bcnt == flen - 11'd1;
      end else if (hs || state_nxt != SEND) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// Directed bench for eth_tx_frame_buffer with a byte scoreboard queue.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_eth_tx_frame_buffer;
  localparam int MAX = 379;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ovf_cnt;
  int   exp_len;
  logic [7:0] exp_q [$];

  eth_tx_frame_buffer_if bus();

  eth_tx_frame_buffer dut (
    .clk_100_mhz(clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input int mode, input bit lw);
    int acc;
    logic [31:0] w;
    acc = 0;
    ovf_cnt = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        1:       w = 32'hAABBCCDD;
        default: w = $urandom;
      endcase
      @(negedge clk);
      if (bus.overflow) ovf_cnt++;
      chk("rdy_wr", 32'(bus.tx_ready_to_write), 32'(acc < MAX));
      bus.tx_valid   = 1'b1;
      bus.tx_data_in = w;
      bus.last_data  = lw && (i == n - 1);
      if (acc < MAX) begin
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        acc++;
      end
    end
    @(negedge clk);
    if (bus.overflow) ovf_cnt++;
    bus.tx_valid = 1'b0;
    if (!lw) begin
      bus.last_data = 1'b1;
      @(negedge clk);
    end
    bus.last_data = 1'b0;
    exp_len = (4 * acc < 60) ? 60 : 4 * acc;
    while (exp_q.size() < exp_len) exp_q.push_back(8'h00);
    chk("rdy_send", 32'(bus.tx_ready_to_send), 32'd1);
    chk("frame_len", 32'(bus.frame_len), 32'(exp_len));
    chk("ovf_idle", 32'(bus.overflow), 32'd0);
    chk("rdy_wr_loaded", 32'(bus.tx_ready_to_write), 32'd0);
  endtask

  task automatic send(input bit rnd, input int abort_at);
    int hs;
    int cyc;
    logic stall;
    logic [7:0] hd;
    logic hl;
    logic [7:0] e;
    @(negedge clk);
    bus.tx_send = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    chk("rdy_send_drop", 32'(bus.tx_ready_to_send), 32'd0);
    chk("lat_e1", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    chk("lat_e2", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    chk("lat_e3", 32'(bus.m_valid), 32'd1);
    hs = 0;
    cyc = 0;
    stall = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (exp_q.size() > 0 && cyc < 20000 && hs != abort_at) begin
      if (stall) begin
        chk("hold_data", 32'(bus.m_data), 32'(hd));
        chk("hold_last", 32'(bus.m_last), 32'(hl));
      end
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        chk("byte", 32'(bus.m_data), 32'(e));
        chk("m_last", 32'(bus.m_last), 32'(exp_q.size() == 0));
        hs++;
      end
      stall = bus.m_valid && !bus.m_ready;
      hd = bus.m_data;
      hl = bus.m_last;
      cyc++;
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    chk("cycle_budget", 32'(cyc < 20000), 32'd1);
    if (hs == abort_at) return;
    chk("hs_count", 32'(hs), 32'(exp_len));
    if (!rnd) chk("no_gaps", 32'(cyc), 32'(hs));
    chk("tx_done", 32'(bus.tx_done), 32'd1);
    chk("m_valid_done", 32'(bus.m_valid), 32'd0);
    chk("m_last_done", 32'(bus.m_last), 32'd0);
    @(negedge clk);
    chk("tx_done_pulse", 32'(bus.tx_done), 32'd0);
    chk("rdy_wr_refill", 32'(bus.tx_ready_to_write), 32'd1);
  endtask

  initial begin
    bus.tx_data_in = '0;
    bus.tx_valid   = 1'b0;
    bus.last_data  = 1'b0;
    bus.tx_send    = 1'b0;
    bus.m_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy_wr", 32'(bus.tx_ready_to_write), 32'd0);
    chk("rst_rdy_send", 32'(bus.tx_ready_to_send), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_frame_len", 32'(bus.frame_len), 32'd0);
    rst_n = 1'b1;
    #1 chk("rdy_wr_pre_edge", 32'(bus.tx_ready_to_write), 32'd0);
    @(negedge clk);
    chk("rdy_wr_post_edge", 32'(bus.tx_ready_to_write), 32'd1);

    fill(16, 0, 1'b0);
    send(1'b0, -1);

    fill(3, 1, 1'b0);
    send(1'b0, -1);

    fill(16, 0, 1'b1);
    send(1'b1, -1);

    fill(381, 2, 1'b0);
    chk("ovf_pulses", 32'(ovf_cnt), 32'd2);
    send(1'b0, -1);

    @(negedge clk);
    bus.last_data = 1'b1;
    @(negedge clk);
    bus.last_data = 1'b0;
    bus.tx_send   = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_m_valid", 32'(bus.m_valid), 32'd0);
      chk("empty_rdy_send", 32'(bus.tx_ready_to_send), 32'd0);
      chk("empty_tx_done", 32'(bus.tx_done), 32'd0);
    end
    fill(1, 2, 1'b0);
    send(1'b0, -1);

    fill(16, 0, 1'b0);
    send(1'b0, 20);
    chk("mid_send_valid", 32'(bus.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_m_last", 32'(bus.m_last), 32'd0);
    chk("arst_tx_done", 32'(bus.tx_done), 32'd0);
    chk("arst_rdy_wr", 32'(bus.tx_ready_to_write), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy_wr", 32'(bus.tx_ready_to_write), 32'd1);
    fill(2, 2, 1'b1);
    send(1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
